operand_keypad: RTL and testbench

Front-end input controller for the board-level ALU demo. It turns the six raw pushbuttons and the 32 slide switches into clean, clock-synchronous register loads for operand A, operand B, the ALU opcode and the display-mode selector. It replaces edge-on-OR-of-buttons clocking with a single-clock debounced, chord-aware state machine. Its outputs drive the ALU operand inputs and the display data mux directly.

---
 rtl/operand_keypad_pkg.sv | 28 ++
 rtl/operand_keypad_if.sv | 25 ++
 rtl/key_debounce.sv | 38 +++
 rtl/operand_keypad.sv | 128 ++++++++++++
 tb/tb_operand_keypad.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/operand_keypad_pkg.sv
// Shared types and button-mask constants for the operand keypad.
// Masks are written leftmost-bit-first to match swb[1:6].
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        APPLY,
        DRAIN
    } kp_state_t;

    localparam int OP_W = 3;
    localparam int NBTN = 6;

    localparam logic [1:NBTN] BTN_A   = 6'b100000;
    localparam logic [1:NBTN] BTN_B   = 6'b010000;
    localparam logic [1:NBTN] BTN_OP  = 6'b001000;
    localparam logic [1:NBTN] SHOW_A  = 6'b000100;
    localparam logic [1:NBTN] SHOW_B  = 6'b000010;
    localparam logic [1:NBTN] SHOW_F  = 6'b000001;
    localparam logic [1:NBTN] SHOW_SW = 6'b000110;

    function automatic logic is_chord(input logic [1:NBTN] m);
        return m inside {BTN_A, BTN_B, BTN_OP,
                         SHOW_A, SHOW_B, SHOW_F, SHOW_SW};
    endfunction

endpackage

// File: rtl/operand_keypad_if.sv
// Switch/button inputs and decoded register outputs of the keypad.
// slave = keypad controller, master = board / test driver.
interface operand_keypad_if;
    import keypad_pkg::*;

    logic [1:32]     sw;
    logic [1:NBTN]   swb;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    logic [OP_W-1:0] alu_op;
    logic [1:NBTN]   show_mode;
    logic [1:NBTN]   load_pulse;
    logic            busy;

    modport master (
        output sw, swb,
        input  a_reg, b_reg, alu_op, show_mode, load_pulse, busy
    );

    modport slave (
        input  sw, swb,
        output a_reg, b_reg, alu_op, show_mode, load_pulse, busy
    );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer followed by a stability counter.
// level flips only after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/operand_keypad.sv
// Debounced, chord-aware loader for ALU operands, opcode and display mode.
// Optional hold timeout: define KEY_TIMEOUT_EN.
module operand_keypad
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_LIMIT      = 300_000_000
) (
    input logic              clk,
    input logic              rst,
    operand_keypad_if.slave  bus
);

    logic [1:NBTN]   acc;
    kp_state_t       state;
    logic [1:32]     snap;
    logic [1:NBTN]   mask;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [OP_W-1:0] op_q;
    logic [1:NBTN]   show_q;
    logic [1:NBTN]   pulse_q;
    logic            busy_q;

`ifdef KEY_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_LIMIT + 1);
    logic [HW-1:0] hold_cnt;
`endif

    for (genvar i = 1; i <= NBTN; i++) begin : g_btn
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.swb[i]),
            .level(acc[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            snap    <= '0;
            mask    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            show_q  <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
`ifdef KEY_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            pulse_q <= '0;
            unique case (state)
                IDLE: begin
`ifdef KEY_TIMEOUT_EN
                    hold_cnt <= '0;
`endif
                    if (|acc) begin
                        snap   <= bus.sw;
                        mask   <= acc;
                        state  <= COLLECT;
                        busy_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    mask <= mask | acc;
`ifdef KEY_TIMEOUT_EN
                    hold_cnt <= hold_cnt + HW'(1);
                    if (acc == '0) begin
                        state <= APPLY;
                    end else if (hold_cnt == HW'(HOLD_LIMIT - 1)) begin
                        mask  <= '0;
                        state <= DRAIN;
                    end
`else
                    if (acc == '0) begin
                        state <= APPLY;
                    end
`endif
                end
                APPLY: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    pulse_q <= is_chord(mask) ? mask : '0;
                    unique case (1'b1)
                        (mask == BTN_A): begin
                            a_q    <= snap;
                            show_q <= BTN_A;
                        end
                        (mask == BTN_B): begin
                            b_q    <= snap;
                            show_q <= BTN_B;
                        end
                        (mask == BTN_OP): begin
                            op_q   <= snap[2:4];
                            show_q <= BTN_OP;
                        end
                        (mask == SHOW_A),
                        (mask == SHOW_B),
                        (mask == SHOW_F): show_q <= mask;
                        (mask == SHOW_SW): show_q <= '0;
                        default: ;
                    endcase
                end
                DRAIN: begin
                    // Aborted chord: nothing is applied, just wait out the release.
                    if (acc == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_reg      = a_q;
    assign bus.b_reg      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.show_mode  = show_q;
    assign bus.load_pulse = pulse_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_operand_keypad.sv
// Directed bench for operand_keypad with DEBOUNCE_CYCLES=4, HOLD_LIMIT=50.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_operand_keypad;
    import keypad_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passes = 0;
    int   total  = 0;
    int   pulse_cnt = 0;
    logic [1:6] pulse_val = '0;
    logic busy_seen = 1'b0;

    operand_keypad_if bus ();

    operand_keypad #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_LIMIT     (50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.load_pulse !== 6'b000000) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_val = bus.load_pulse;
        end
        if (bus.busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic clr_mon();
        pulse_cnt = 0;
        pulse_val = '0;
        busy_seen = 1'b0;
    endtask

    task automatic chord(input logic [1:6] b, input logic [31:0] s,
                         input int hold);
        bus.sw  = s;
        bus.swb = b;
        tick(hold);
        bus.swb = '0;
        tick(12);
    endtask

    initial begin
        bus.sw  = '0;
        bus.swb = '0;
        tick(3);
        chk("rst_a", bus.a_reg, 0);
        chk("rst_b", bus.b_reg, 0);
        chk("rst_op", 32'(bus.alu_op), 0);
        chk("rst_show", 32'(bus.show_mode), 0);
        chk("rst_pulse", 32'(bus.load_pulse), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        tick(2);

        // A load with exact press/release latency
        clr_mon();
        bus.sw  = 32'h1234_5678;
        bus.swb = BTN_A;
        tick(6);
        chk("a_busy_pre", 32'(bus.busy), 0);
        tick(1);
        chk("a_busy_on", 32'(bus.busy), 1);
        tick(5);
        bus.swb = '0;
        tick(7);
        chk("a_early", bus.a_reg, 0);
        chk("a_busy_apply", 32'(bus.busy), 1);
        tick(1);
        chk("a_reg", bus.a_reg, 32'h1234_5678);
        chk("a_pulse", 32'(bus.load_pulse), 32'(BTN_A));
        chk("a_show", 32'(bus.show_mode), 32'(BTN_A));
        chk("a_busy_off", 32'(bus.busy), 0);
        tick(1);
        chk("a_pulse_end", 32'(bus.load_pulse), 0);
        chk("a_pulse_cnt", pulse_cnt, 1);

        // Opcode from sw[2:4]; switch change during hold ignored
        clr_mon();
        bus.sw  = 32'h7000_0000;
        bus.swb = BTN_OP;
        tick(10);
        bus.sw  = '0;
        bus.swb = '0;
        tick(12);
        chk("op_val", 32'(bus.alu_op), 7);
        chk("op_show", 32'(bus.show_mode), 32'(BTN_OP));
        chk("op_pulse", 32'(pulse_val), 32'(BTN_OP));
        chk("op_pulse_cnt", pulse_cnt, 1);
        chk("op_a_kept", bus.a_reg, 32'h1234_5678);

        // Show-F single display select
        clr_mon();
        chord(SHOW_F, 32'h0, 8);
        chk("f_show", 32'(bus.show_mode), 32'(SHOW_F));

        // Two-step chord SHOW_A then SHOW_B -> live switches
        clr_mon();
        bus.swb = SHOW_A;
        tick(8);
        bus.swb = SHOW_SW;
        tick(8);
        bus.swb = '0;
        tick(12);
        chk("sw_show", 32'(bus.show_mode), 0);
        chk("sw_pulse", 32'(pulse_val), 32'(SHOW_SW));
        chk("sw_pulse_cnt", pulse_cnt, 1);

        // Same-cycle hand-off SHOW_A -> SHOW_B still ORs into SHOW_SW
        chord(SHOW_F, 32'h0, 8);
        clr_mon();
        bus.swb = SHOW_A;
        tick(10);
        bus.swb = SHOW_B;
        tick(10);
        bus.swb = '0;
        tick(12);
        chk("swap_pulse", 32'(pulse_val), 32'(SHOW_SW));
        chk("swap_show", 32'(bus.show_mode), 0);

        // 3-cycle glitch is rejected
        clr_mon();
        bus.sw  = 32'hDEAD_BEEF;
        bus.swb = BTN_A;
        tick(3);
        bus.swb = '0;
        tick(12);
        chk("gl_busy_seen", 32'(busy_seen), 0);
        chk("gl_a", bus.a_reg, 32'h1234_5678);
        chk("gl_pulse_cnt", pulse_cnt, 0);

        // Invalid chord: no loads, back to IDLE
        clr_mon();
        chord(BTN_A | BTN_B, 32'hCAFE_F00D, 10);
        chk("inv_a", bus.a_reg, 32'h1234_5678);
        chk("inv_b", bus.b_reg, 0);
        chk("inv_pulse_cnt", pulse_cnt, 0);
        chk("inv_busy_seen", 32'(busy_seen), 1);
        chk("inv_busy", 32'(bus.busy), 0);
        clr_mon();
        chord(BTN_B, 32'h0BAD_C0DE, 8);
        chk("b_reg", bus.b_reg, 32'h0BAD_C0DE);
        chk("b_pulse", 32'(pulse_val), 32'(BTN_B));

        // Long hold of B
        clr_mon();
        bus.sw  = 32'h5555_5555;
        bus.swb = BTN_B;
        tick(66);
`ifdef KEY_TIMEOUT_EN
        chk("to_drain", 32'(dut.state), 32'(DRAIN));
        chk("to_busy", 32'(bus.busy), 1);
        bus.swb = '0;
        tick(6);
        chk("to_busy_hold", 32'(bus.busy), 1);
        tick(2);
        chk("to_busy_off", 32'(bus.busy), 0);
        chk("to_b", bus.b_reg, 32'h0BAD_C0DE);
        chk("to_pulse_cnt", pulse_cnt, 0);
`else
        chk("long_busy", 32'(bus.busy), 1);
        bus.swb = '0;
        tick(12);
        chk("long_b", bus.b_reg, 32'h5555_5555);
        chk("long_pulse_cnt", pulse_cnt, 1);
`endif

        // Reset mid-hold, then the still-held button re-chords
        clr_mon();
        bus.sw  = 32'h1111_2222;
        bus.swb = BTN_A;
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("mr_a", bus.a_reg, 0);
        chk("mr_b", bus.b_reg, 0);
        chk("mr_op", 32'(bus.alu_op), 0);
        chk("mr_show", 32'(bus.show_mode), 0);
        chk("mr_pulse", 32'(bus.load_pulse), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        tick(6);
        chk("mr_busy_pre", 32'(bus.busy), 0);
        tick(2);
        chk("mr_busy_new", 32'(bus.busy), 1);
        bus.swb = '0;
        tick(12);
        chk("mr_a_new", bus.a_reg, 32'h1111_2222);
        chk("mr_pulse_new", 32'(pulse_val), 32'(BTN_A));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
